// File: rtl/idle_power_req_gen.sv
// Idle-timeout power-gating policy: requests power-off after a run of idle cycles and
// power-on on wake (after a minimum off-residency), and keeps gating statistics.
module idle_power_req_gen #(
   parameter int IDLE_THRESH = 100,
   parameter int MIN_OFF     = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             block_busy,
   input  logic             wake_req,
   input  logic             power_on_ack,
   input  logic             power_off_ack,
   output logic             power_on_req,
   output logic             power_off_req,
   output logic             gated,
   output logic             wake_pending,
   output logic [CNT_W-1:0] off_count,
   output logic [CNT_W-1:0] gated_cycles
);

   localparam int THR    = (IDLE_THRESH < 1) ? 1 : IDLE_THRESH;
   localparam int IDLE_W = $clog2(THR + 1);
   localparam int RES_W  = (MIN_OFF < 1) ? 1 : $clog2(MIN_OFF + 1);

   typedef enum logic [1:0] {
      S_OFF     = 2'd0,
      S_REQ_ON  = 2'd1,
      S_ACTIVE  = 2'd2,
      S_REQ_OFF = 2'd3
   } state_t;

   state_t             state_reg, state_next;
   logic [IDLE_W-1:0]  idle_cnt_reg, idle_cnt_next;
   logic [RES_W-1:0]   res_cnt_reg, res_cnt_next;
   logic               off_done;
   logic               idle_cycle;

   logic               power_on_req_next, power_off_req_next, gated_next, wake_pending_next;
   logic [CNT_W-1:0]   off_count_next, gated_cycles_next;

   // A wake event also counts as activity so a waking block is not immediately re-gated.
   assign idle_cycle = enable && !block_busy && !wake_req;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= S_OFF;
         idle_cnt_reg <= '0;
         res_cnt_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         idle_cnt_reg <= idle_cnt_next;
         res_cnt_reg  <= res_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      idle_cnt_next = idle_cnt_reg;
      res_cnt_next  = res_cnt_reg;
      off_done      = 1'b0;
      case (state_reg)
         S_OFF: begin
            if (res_cnt_reg != '0)
               res_cnt_next = res_cnt_reg - 1'b1;
            else if (wake_pending || wake_req)
               state_next = S_REQ_ON;
         end
         S_REQ_ON: begin
            if (power_on_ack) begin
               state_next    = S_ACTIVE;
               idle_cnt_next = '0;
            end
         end
         S_ACTIVE: begin
            if (!idle_cycle) begin
               idle_cnt_next = '0;
            end else if (idle_cnt_reg == IDLE_W'(THR - 1)) begin
               state_next    = S_REQ_OFF;
               idle_cnt_next = '0;
            end else begin
               idle_cnt_next = idle_cnt_reg + 1'b1;
            end
         end
         S_REQ_OFF: begin
            if (power_off_ack) begin
               state_next   = S_OFF;
               res_cnt_next = RES_W'(MIN_OFF);
               off_done     = 1'b1;
            end
         end
         default: state_next = S_OFF;
      endcase
   end

   always_comb begin
      power_on_req_next  = (state_next == S_REQ_ON);
      power_off_req_next = (state_next == S_REQ_OFF);
      gated_next         = (state_next == S_OFF) || (state_next == S_REQ_ON);
      // Entering ACTIVE services the wake, even if another wake arrives on that edge.
      if (state_next == S_ACTIVE && state_reg != S_ACTIVE)
         wake_pending_next = 1'b0;
      else if (wake_req && state_reg != S_ACTIVE)
         wake_pending_next = 1'b1;
      else
         wake_pending_next = wake_pending;
      off_count_next    = (off_done && !(&off_count)) ? off_count + 1'b1 : off_count;
      gated_cycles_next = (gated && !(&gated_cycles)) ? gated_cycles + 1'b1 : gated_cycles;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         power_on_req  <= 1'b0;
         power_off_req <= 1'b0;
         gated         <= 1'b1;
         wake_pending  <= 1'b0;
         off_count     <= '0;
         gated_cycles  <= '0;
      end else begin
         power_on_req  <= power_on_req_next;
         power_off_req <= power_off_req_next;
         gated         <= gated_next;
         wake_pending  <= wake_pending_next;
         off_count     <= off_count_next;
         gated_cycles  <= gated_cycles_next;
      end
   end

endmodule
